// File: rtl/sevenseg_pkg.sv
// sevenseg_pkg: register map, CTRL field positions, STATUS id and segment helpers
package sevenseg_pkg;

    localparam logic [2:0] OFF_CTRL   = 3'd0;
    localparam logic [2:0] OFF_DATA   = 3'd1;
    localparam logic [2:0] OFF_RAW_LO = 3'd2;
    localparam logic [2:0] OFF_RAW_HI = 3'd3;
    localparam logic [2:0] OFF_STATUS = 3'd4;

    localparam int CTRL_EN       = 0;
    localparam int CTRL_RAW      = 1;
    localparam int CTRL_MASK_LSB = 8;
    localparam int CTRL_DP_LSB   = 16;

    localparam logic [15:0] STATUS_ID   = 16'h5E61;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    typedef enum logic {WR_IDLE, WR_RESP} wr_state_t;
    typedef enum logic {RD_IDLE, RD_RESP} rd_state_t;

    // Slot length in clocks; short slots would leave no room after the blank window.
    function automatic int slot_len(input int clk_hz, input int refresh_hz);
        int s;
        s = clk_hz / (refresh_hz * 8);
        return (s < 16) ? 16 : s;
    endfunction

    // Active-high segments {g,f,e,d,c,b,a} for one hex nibble.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
        case (n)
            4'h0: return 7'h3F;
            4'h1: return 7'h06;
            4'h2: return 7'h5B;
            4'h3: return 7'h4F;
            4'h4: return 7'h66;
            4'h5: return 7'h6D;
            4'h6: return 7'h7D;
            4'h7: return 7'h07;
            4'h8: return 7'h7F;
            4'h9: return 7'h6F;
            4'hA: return 7'h77;
            4'hB: return 7'h7C;
            4'hC: return 7'h39;
            4'hD: return 7'h5E;
            4'hE: return 7'h79;
            default: return 7'h71;
        endcase
    endfunction

    // Merge a write beat into a register honouring byte enables.
    function automatic logic [31:0] apply_strb(input logic [31:0] old_v, input logic [31:0] new_v,
                                               input logic [3:0] strb);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[i*8 +: 8] = strb[i] ? new_v[i*8 +: 8] : old_v[i*8 +: 8];
        return r;
    endfunction

endpackage

// File: rtl/axi_lite_sevenseg_if.sv
// axi_lite_sevenseg_if: AXI4-Lite bus bundle between the PS master and the display slave
interface axi_lite_sevenseg_if;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/sevenseg_scan.sv
// sevenseg_scan: slot prescaler and digit counter for the multiplexed display
module sevenseg_scan
    import sevenseg_pkg::*;
#(
    parameter int CLK_FREQ_HZ  = 100000000,
    parameter int REFRESH_HZ   = 1000,
    parameter int BLANK_CYCLES = 64
) (
    input  logic       clk,
    input  logic       resetn,
    output logic [2:0] o_digit,
    output logic       o_blank,
    output logic       o_frame_wrap
);
    localparam int SLOT = slot_len(CLK_FREQ_HZ, REFRESH_HZ);
    localparam int PW   = $clog2(SLOT);

    logic [PW-1:0] r_presc;
    logic [2:0]    r_digit;
    logic          w_slot_end;

    assign w_slot_end   = r_presc == PW'(SLOT - 1);
    assign o_digit      = r_digit;
    assign o_blank      = r_presc < PW'(BLANK_CYCLES);
    assign o_frame_wrap = w_slot_end && (r_digit == 3'd7);

    // Count cycles within a slot and step to the next digit on wrap (7 rolls to 0).
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_presc <= '0;
            r_digit <= '0;
        end else begin
            r_presc <= w_slot_end ? '0 : r_presc + 1'b1;
            if (w_slot_end) r_digit <= r_digit + 3'd1;
        end
    end
endmodule

// File: rtl/axi_lite_sevenseg.sv
// axi_lite_sevenseg: AXI4-Lite register block driving an 8-digit multiplexed seven-segment display
module axi_lite_sevenseg
    import sevenseg_pkg::*;
#(
    parameter int CLK_FREQ_HZ  = 100000000,
    parameter int REFRESH_HZ   = 1000,
    parameter int BLANK_CYCLES = 64
) (
    input  logic                    clk,
    input  logic                    resetn,
    axi_lite_sevenseg_if.slave      s_axi,
    output logic [6:0]              seg_n,
    output logic                    dp_n,
    output logic [7:0]              an_n
);
    logic        r_init;
    wr_state_t   r_wr_state, w_wr_next;
    rd_state_t   r_rd_state, w_rd_next;
    logic        r_aw_held, r_w_held;
    logic [2:0]  r_aw_off;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic [1:0]  r_bresp, r_rresp;
    logic [31:0] r_rdata;
    logic [31:0] r_ctrl, r_data, r_raw_lo, r_raw_hi;
    logic [31:0] w_ctrl_nxt, w_data_nxt, w_raw_lo_nxt, w_raw_hi_nxt;
    logic [31:0] r_sh_ctrl, r_sh_data;
    logic [63:0] r_sh_raw;
    logic [6:0]  r_seg_n;
    logic        r_dp_n;
    logic [7:0]  r_an_n;
    logic        w_aw_hs, w_w_hs, w_ar_hs, w_commit, w_wr_err;
    logic [2:0]  w_rd_off, w_digit;
    logic [31:0] w_rd_data;
    logic [1:0]  w_rd_resp;
    logic        w_blank, w_frame_wrap, w_on, w_dp;
    logic [7:0]  w_raw_byte;
    logic [3:0]  w_nib;
    logic [6:0]  w_seg;
    logic        w_unused;

    sevenseg_scan #(
        .CLK_FREQ_HZ (CLK_FREQ_HZ),
        .REFRESH_HZ  (REFRESH_HZ),
        .BLANK_CYCLES(BLANK_CYCLES)
    ) u_scan (
        .clk         (clk),
        .resetn      (resetn),
        .o_digit     (w_digit),
        .o_blank     (w_blank),
        .o_frame_wrap(w_frame_wrap)
    );

    assign s_axi.awready = r_init && (r_wr_state == WR_IDLE) && !r_aw_held;
    assign s_axi.wready  = r_init && (r_wr_state == WR_IDLE) && !r_w_held;
    assign s_axi.bvalid  = r_wr_state == WR_RESP;
    assign s_axi.bresp   = r_bresp;
    assign s_axi.arready = r_init && (r_rd_state == RD_IDLE);
    assign s_axi.rvalid  = r_rd_state == RD_RESP;
    assign s_axi.rdata   = r_rdata;
    assign s_axi.rresp   = r_rresp;
    assign seg_n = r_seg_n;
    assign dp_n  = r_dp_n;
    assign an_n  = r_an_n;

    assign w_aw_hs  = s_axi.awvalid && s_axi.awready;
    assign w_w_hs   = s_axi.wvalid && s_axi.wready;
    assign w_ar_hs  = s_axi.arvalid && s_axi.arready;
    assign w_commit = (r_wr_state == WR_IDLE) && r_aw_held && r_w_held;
    assign w_wr_err = r_aw_off[2];
    assign w_rd_off = s_axi.araddr[4:2];

    assign w_unused = &{1'b0, s_axi.awaddr[31:5], s_axi.awaddr[1:0], s_axi.araddr[31:5],
                        s_axi.araddr[1:0], s_axi.awprot, s_axi.arprot, r_sh_ctrl[31:24], r_sh_ctrl[7:2]};

    // Bus FSM next state plus the post-write register image, which reads also see.
    always_comb begin
        w_wr_next    = w_commit ? WR_RESP : (r_wr_state == WR_RESP && s_axi.bready) ? WR_IDLE : r_wr_state;
        w_rd_next    = w_ar_hs ? RD_RESP : (r_rd_state == RD_RESP && s_axi.rready) ? RD_IDLE : r_rd_state;
        w_ctrl_nxt   = (w_commit && r_aw_off == OFF_CTRL) ? apply_strb(r_ctrl, r_wdata, r_wstrb) : r_ctrl;
        w_data_nxt   = (w_commit && r_aw_off == OFF_DATA) ? apply_strb(r_data, r_wdata, r_wstrb) : r_data;
        w_raw_lo_nxt = (w_commit && r_aw_off == OFF_RAW_LO) ? apply_strb(r_raw_lo, r_wdata, r_wstrb) : r_raw_lo;
        w_raw_hi_nxt = (w_commit && r_aw_off == OFF_RAW_HI) ? apply_strb(r_raw_hi, r_wdata, r_wstrb) : r_raw_hi;
        w_rd_data    = (w_rd_off == OFF_CTRL)   ? w_ctrl_nxt :
                       (w_rd_off == OFF_DATA)   ? w_data_nxt :
                       (w_rd_off == OFF_RAW_LO) ? w_raw_lo_nxt :
                       (w_rd_off == OFF_RAW_HI) ? w_raw_hi_nxt :
                       (w_rd_off == OFF_STATUS) ? {STATUS_ID, 13'd0, w_digit} : 32'd0;
        w_rd_resp    = (w_rd_off[2] && w_rd_off != OFF_STATUS) ? RESP_SLVERR : RESP_OKAY;
    end

    // Hold the ready lines low until the first clock after reset release; advance bus FSMs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_init     <= 1'b0;
            r_wr_state <= WR_IDLE;
            r_rd_state <= RD_IDLE;
        end else begin
            r_init     <= 1'b1;
            r_wr_state <= w_wr_next;
            r_rd_state <= w_rd_next;
        end
    end

    // Capture AW and W beats independently; commit them together one cycle after both are held.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_aw_off  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_bresp   <= RESP_OKAY;
            r_ctrl    <= '0;
            r_data    <= '0;
            r_raw_lo  <= '0;
            r_raw_hi  <= '0;
        end else begin
            if (w_aw_hs) begin
                r_aw_held <= 1'b1;
                r_aw_off  <= s_axi.awaddr[4:2];
            end else if (w_commit) begin
                r_aw_held <= 1'b0;
            end
            if (w_w_hs) begin
                r_w_held <= 1'b1;
                r_wdata  <= s_axi.wdata;
                r_wstrb  <= s_axi.wstrb;
            end else if (w_commit) begin
                r_w_held <= 1'b0;
            end
            if (w_commit) r_bresp <= w_wr_err ? RESP_SLVERR : RESP_OKAY;
            r_ctrl   <= w_ctrl_nxt;
            r_data   <= w_data_nxt;
            r_raw_lo <= w_raw_lo_nxt;
            r_raw_hi <= w_raw_hi_nxt;
        end
    end

    // Register read data and response at address acceptance.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rdata <= '0;
            r_rresp <= RESP_OKAY;
        end else if (w_ar_hs) begin
            r_rdata <= w_rd_data;
            r_rresp <= w_rd_resp;
        end
    end

    // Snapshot the display registers only at frame wrap so a frame never shows mixed data.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sh_ctrl <= '0;
            r_sh_data <= '0;
            r_sh_raw  <= '0;
        end else if (w_frame_wrap) begin
            r_sh_ctrl <= r_ctrl;
            r_sh_data <= r_data;
            r_sh_raw  <= {r_raw_hi, r_raw_lo};
        end
    end

    // Select the lit pattern for the current digit; blank window or masked digit forces all off.
    always_comb begin
        w_on       = !w_blank && r_sh_ctrl[CTRL_EN] && r_sh_ctrl[CTRL_MASK_LSB + 32'(w_digit)];
        w_raw_byte = r_sh_raw[{w_digit, 3'b000} +: 8];
        w_nib      = r_sh_data[{w_digit, 2'b00} +: 4];
        w_seg      = r_sh_ctrl[CTRL_RAW] ? w_raw_byte[6:0] : hex_to_seg(w_nib);
        w_dp       = r_sh_ctrl[CTRL_RAW] ? w_raw_byte[7] : r_sh_ctrl[CTRL_DP_LSB + 32'(w_digit)];
    end

    // Register the pin drivers; reset blanks the display immediately.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_an_n  <= 8'hFF;
            r_seg_n <= 7'h7F;
            r_dp_n  <= 1'b1;
        end else begin
            r_an_n  <= w_on ? ~(8'd1 << w_digit) : 8'hFF;
            r_seg_n <= w_on ? ~w_seg : 7'h7F;
            r_dp_n  <= w_on ? ~w_dp : 1'b1;
        end
    end
endmodule

// File: tb/tb_axi_lite_sevenseg.sv
// tb_axi_lite_sevenseg: directed register and display checks for axi_lite_sevenseg
module tb_axi_lite_sevenseg;
    logic       clk;
    logic       resetn;
    logic [6:0] seg_n;
    logic       dp_n;
    logic [7:0] an_n;
    int         n_checks;
    int         n_errors;
    int         n;
    logic [31:0] rd;
    logic [1:0]  rs;

    axi_lite_sevenseg_if s_axi();

    axi_lite_sevenseg #(
        .CLK_FREQ_HZ (1600),
        .REFRESH_HZ  (10),
        .BLANK_CYCLES(4)
    ) dut (
        .clk   (clk),
        .resetn(resetn),
        .s_axi (s_axi),
        .seg_n (seg_n),
        .dp_n  (dp_n),
        .an_n  (an_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
        bit aw_done = 0;
        bit w_done = 0;
        int k = 0;
        @(negedge clk);
        s_axi.awaddr = a; s_axi.awvalid = 1'b1;
        s_axi.wdata = d; s_axi.wstrb = s; s_axi.wvalid = 1'b1;
        while (!(aw_done && w_done) && k < 50) begin
            bit aw_hs = s_axi.awvalid && s_axi.awready;
            bit w_hs = s_axi.wvalid && s_axi.wready;
            @(negedge clk);
            if (aw_hs) begin s_axi.awvalid = 1'b0; aw_done = 1; end
            if (w_hs) begin s_axi.wvalid = 1'b0; w_done = 1; end
            k++;
        end
        s_axi.awvalid = 1'b0; s_axi.wvalid = 1'b0;
        s_axi.bready = 1'b1;
        while (!s_axi.bvalid && k < 100) begin @(negedge clk); k++; end
        chk("wr_bvalid", {31'd0, s_axi.bvalid}, 32'd1);
        resp = s_axi.bresp;
        @(negedge clk);
        s_axi.bready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
        int k = 0;
        @(negedge clk);
        s_axi.araddr = a; s_axi.arvalid = 1'b1;
        while (!s_axi.arready && k < 50) begin @(negedge clk); k++; end
        @(negedge clk);
        s_axi.arvalid = 1'b0; s_axi.rready = 1'b1;
        while (!s_axi.rvalid && k < 100) begin @(negedge clk); k++; end
        chk("rd_rvalid", {31'd0, s_axi.rvalid}, 32'd1);
        d = s_axi.rdata; resp = s_axi.rresp;
        @(negedge clk);
        s_axi.rready = 1'b0;
    endtask

    task automatic wait_an(input string tag, input logic [7:0] target);
        int k = 0;
        while (an_n !== target && k < 400) begin @(negedge clk); k++; end
        chk(tag, {24'd0, an_n}, {24'd0, target});
    endtask

    initial begin
        n_checks = 0; n_errors = 0;
        resetn = 1'b0;
        s_axi.awaddr = '0; s_axi.awprot = '0; s_axi.awvalid = 1'b0;
        s_axi.wdata = '0; s_axi.wstrb = '0; s_axi.wvalid = 1'b0; s_axi.bready = 1'b0;
        s_axi.araddr = '0; s_axi.arprot = '0; s_axi.arvalid = 1'b0; s_axi.rready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_an", {24'd0, an_n}, 32'hFF);
        chk("rst_seg", {25'd0, seg_n}, 32'h7F);
        chk("rst_dp", {31'd0, dp_n}, 32'd1);
        chk("rst_valid", {30'd0, s_axi.bvalid, s_axi.rvalid}, 32'd0);
        chk("rst_ready", {29'd0, s_axi.awready, s_axi.wready, s_axi.arready}, 32'd0);
        resetn = 1'b1;
        @(negedge clk);
        chk("rdy_after_rst", {29'd0, s_axi.awready, s_axi.wready, s_axi.arready}, 32'h7);
        axi_read(32'h10, rd, rs);
        chk("status", rd, 32'h5E610000);
        chk("status_resp", {30'd0, rs}, 32'd0);
        axi_read(32'h00, rd, rs);
        chk("ctrl_rst", rd, 32'd0);

        axi_write(32'h04, 32'h76543210, 4'hF, rs);
        chk("wr_data_resp", {30'd0, rs}, 32'd0);
        axi_write(32'h00, 32'h0000FF01, 4'hF, rs);
        chk("wr_ctrl_resp", {30'd0, rs}, 32'd0);
        chk("pre_wrap_dark", {24'd0, an_n}, 32'hFF);
        axi_read(32'h00, rd, rs);
        chk("ctrl_rb", rd, 32'h0000FF01);
        wait_an("d3_an", 8'hF7);
        chk("d3_seg", {25'd0, seg_n}, 32'h30);
        chk("d3_dp", {31'd0, dp_n}, 32'd1);
        repeat (16) @(negedge clk);
        chk("d4_blank", {24'd0, an_n}, 32'hFF);
        chk("d4_blank_seg", {25'd0, seg_n}, 32'h7F);
        repeat (4) @(negedge clk);
        chk("d4_an", {24'd0, an_n}, 32'hEF);
        chk("d4_seg", {25'd0, seg_n}, 32'h19);

        @(negedge clk);
        s_axi.awaddr = 32'h04; s_axi.awvalid = 1'b1;
        chk("t3_awrdy", {31'd0, s_axi.awready}, 32'd1);
        @(negedge clk);
        s_axi.awvalid = 1'b0;
        chk("t3_aw_held", {30'd0, s_axi.awready, s_axi.wready}, 32'd1);
        repeat (2) @(negedge clk);
        s_axi.wdata = 32'h89ABCDEF; s_axi.wstrb = 4'hF; s_axi.wvalid = 1'b1;
        chk("t3_wrdy", {31'd0, s_axi.wready}, 32'd1);
        @(negedge clk);
        s_axi.wvalid = 1'b0;
        n = 0;
        while (!s_axi.bvalid && n < 10) begin @(negedge clk); n++; end
        for (int i = 0; i < 5; i++) begin
            chk("t3_hold", {29'd0, s_axi.bvalid, s_axi.awready, s_axi.wready}, 32'h4);
            @(negedge clk);
        end
        chk("t3_bresp", {30'd0, s_axi.bresp}, 32'd0);
        s_axi.bready = 1'b1;
        @(negedge clk);
        s_axi.bready = 1'b0;
        chk("t3_bdone", {29'd0, s_axi.bvalid, s_axi.awready, s_axi.wready}, 32'h3);
        axi_read(32'h04, rd, rs);
        chk("t3_data", rd, 32'h89ABCDEF);

        axi_write(32'h14, 32'hFFFFFFFF, 4'hF, rs);
        chk("bad_wr_resp", {30'd0, rs}, 32'h2);
        axi_write(32'h10, 32'hFFFFFFFF, 4'hF, rs);
        chk("status_wr_resp", {30'd0, rs}, 32'h2);
        axi_read(32'h04, rd, rs);
        chk("bad_wr_noeffect", rd, 32'h89ABCDEF);
        axi_read(32'h14, rd, rs);
        chk("bad_rd_data", rd, 32'd0);
        chk("bad_rd_resp", {30'd0, rs}, 32'h2);
        axi_write(32'h04, 32'h11223344, 4'b0010, rs);
        axi_read(32'h04, rd, rs);
        chk("strb_byte1", rd, 32'h89AB33EF);

        axi_write(32'h08, 32'h00000080, 4'hF, rs);
        axi_write(32'h00, 32'h00010103, 4'hF, rs);
        wait_an("raw_sync_d7", 8'h7F);
        wait_an("raw_an", 8'hFE);
        chk("raw_seg", {25'd0, seg_n}, 32'h7F);
        chk("raw_dp", {31'd0, dp_n}, 32'd0);
        repeat (20) @(negedge clk);
        chk("raw_d1_masked", {24'd0, an_n}, 32'hFF);

        axi_write(32'h00, 32'h0000FF01, 4'hF, rs);
        wait_an("hex_sync_d7", 8'h7F);
        wait_an("old_d0_an", 8'hFE);
        chk("old_d0_seg", {25'd0, seg_n}, 32'h0E);
        axi_write(32'h04, 32'h01234567, 4'hF, rs);
        wait_an("old_d3_an", 8'hF7);
        chk("old_d3_seg", {25'd0, seg_n}, 32'h30);
        wait_an("new_d0_an", 8'hFE);
        chk("new_d0_seg", {25'd0, seg_n}, 32'h78);
        wait_an("new_d3_an", 8'hF7);
        chk("new_d3_seg", {25'd0, seg_n}, 32'h19);

        @(negedge clk);
        s_axi.araddr = 32'h00; s_axi.arvalid = 1'b1;
        @(negedge clk);
        s_axi.arvalid = 1'b0;
        chk("mid_rd_rvalid", {31'd0, s_axi.rvalid}, 32'd1);
        resetn = 1'b0;
        #1;
        chk("abort_rvalid", {31'd0, s_axi.rvalid}, 32'd0);
        chk("abort_an", {24'd0, an_n}, 32'hFF);
        chk("abort_seg", {25'd0, seg_n}, 32'h7F);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        axi_read(32'h00, rd, rs);
        chk("ctrl_after_rst", rd, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end
endmodule
